serial_adder_core: RTL

- Mealy-machine serial full-adder plus its controller. Sits directly downstream of the two operand shift registers (A and B) and drives their load/shift controls.
- Consumes one LSB-first operand bit pair per cycle, produces one sum bit per cycle, and assembles the N-bit sum and carry-out with a start/done handshake.

---
 rtl/serial_adder_core.sv | 97 +++++++++
 1 files changed

// File: rtl/serial_adder_core.sv
// Serial LSB-first full adder with its load/shift controller.
// One sum bit per ADD cycle; the N-bit sum and carry-out are assembled in registers.
module serial_adder_core #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_cin,
  input  logic         i_a_bit,
  input  logic         i_b_bit,
  output logic         o_ld,
  output logic         o_shift,
  output logic         o_sum_bit,
  output logic [N-1:0] o_sum,
  output logic         o_cout,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          s, c_nxt;

  assign s     = i_a_bit ^ i_b_bit ^ carry_q;
  assign c_nxt = (i_a_bit & i_b_bit) | (i_a_bit & carry_q) | (i_b_bit & carry_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = LOAD;
      end
      LOAD: begin
        carry_d = i_cin;
        cnt_d   = '0;
        sum_d   = '0;
        cout_d  = 1'b0;
        state_d = ADD;
      end
      ADD: begin
        // Sum bits enter at the MSB so bit 0 lands in place after N shifts.
        sum_d   = {s, sum_q[N-1:1]};
        carry_d = c_nxt;
        if (cnt_q == LAST) begin
          cout_d  = c_nxt;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_ld      = (state_q == LOAD);
  assign o_shift   = (state_q == ADD);
  assign o_done    = (state_q == DONE);
  assign o_busy    = (state_q != IDLE);
  assign o_sum_bit = (state_q == ADD) & s;
  assign o_sum     = sum_q;
  assign o_cout    = cout_q;

endmodule
